// File: rtl/imem_pkg.sv
// rtl/imem_pkg.sv - shared types and helpers for the instruction-memory responder
package imem_pkg;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

    typedef struct packed {
        logic [31:0] instr;
        logic        err;
    } rsp_t;

    // Callers truncate the result to the RAM index width.
    function automatic logic [31:0] word_index(input logic [31:0] byte_addr);
        return byte_addr >> 2;
    endfunction

endpackage

// File: rtl/imem_rsp_fifo.sv
// rtl/imem_rsp_fifo.sv - response FIFO of rsp_t, wrap-bit pointers, async active-low reset
module imem_rsp_fifo
    import imem_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic push,
    input  rsp_t push_data,
    input  logic pop,
    output rsp_t head,
    output logic full,
    output logic empty
);

    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [IW:0] wr_q, wr_d, rd_q, rd_d;
    rsp_t        mem_q [DEPTH];
    rsp_t        mem_d [DEPTH];

    // Index wraps modulo DEPTH; the top bit toggles on each wrap so full/empty differ.
    function automatic logic [IW:0] ptr_inc(input logic [IW:0] p);
        if (p[IW-1:0] == IW'(DEPTH - 1)) begin
            return {~p[IW], {IW{1'b0}}};
        end
        return {p[IW], p[IW-1:0] + IW'(1)};
    endfunction

    assign empty = (wr_q == rd_q);
    assign full  = (wr_q[IW] != rd_q[IW]) && (wr_q[IW-1:0] == rd_q[IW-1:0]);
    assign head  = empty ? '0 : mem_q[rd_q[IW-1:0]];

    always_comb begin
        mem_d = mem_q;
        wr_d  = wr_q;
        rd_d  = rd_q;
        if (push && !full) begin
            mem_d[wr_q[IW-1:0]] = push_data;
            wr_d                = ptr_inc(wr_q);
        end
        if (pop && !empty) begin
            rd_d = ptr_inc(rd_q);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_q <= '0;
            rd_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            mem_q <= mem_d;
        end
    end

endmodule

// File: rtl/imem_responder.sv
// rtl/imem_responder.sv - instruction-memory responder: program RAM, fixed-latency pipe, credit-limited response FIFO
module imem_responder
    import imem_pkg::*;
#(
    parameter int DEPTH  = 256,
    parameter int LAT    = 2,
    parameter int QDEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic [31:0]              req_addr,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [31:0]              rsp_instr,
    output logic                     rsp_err,
    input  logic                     prog_we,
    input  logic [$clog2(DEPTH)-1:0] prog_addr,
    input  logic [31:0]              prog_wdata
);

    localparam int AW = $clog2(DEPTH);
    localparam int OW = $clog2(QDEPTH + 1);

    logic [31:0]   ram_q [DEPTH];
    logic [AW-1:0] rd_idx;
    logic          addr_err;
    logic          accept;
    logic          pop;
    rsp_t          rd_rsp;
    rsp_t          head;
    logic          fifo_push;
    logic          fifo_full;
    logic          fifo_empty;

    logic [OW-1:0] out_q, out_d;
    logic          pipe_vld_q [LAT];
    logic          pipe_vld_d [LAT];
    rsp_t          pipe_rsp_q [LAT];
    rsp_t          pipe_rsp_d [LAT];

    assign rd_idx   = AW'(word_index(req_addr));
    assign addr_err = (req_addr[1:0] != 2'b00) || (req_addr >= 32'(4 * DEPTH));

    // Combinational read before the edge gives read-before-write against prog_we.
    assign rd_rsp.instr = addr_err ? NOP_INSTR : ram_q[rd_idx];
    assign rd_rsp.err   = addr_err;

    // Credits come from the registered count only, so a pop frees a slot one cycle later.
    assign req_ready = rst && (out_q < OW'(QDEPTH));
    assign accept    = req_valid && req_ready;
    assign rsp_valid = !fifo_empty;
    assign pop       = rsp_valid && rsp_ready;
    assign fifo_push = pipe_vld_q[LAT-1];
    assign rsp_instr = head.instr;
    assign rsp_err   = head.err;

    always_comb begin
        out_d = out_q;
        case ({accept, pop})
            2'b10:   out_d = out_q + OW'(1);
            2'b01:   out_d = out_q - OW'(1);
            default: out_d = out_q;
        endcase
        pipe_vld_d[0] = accept;
        pipe_rsp_d[0] = rd_rsp;
        for (int i = 1; i < LAT; i++) begin
            pipe_vld_d[i] = pipe_vld_q[i-1];
            pipe_rsp_d[i] = pipe_rsp_q[i-1];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_q <= '0;
            for (int i = 0; i < LAT; i++) begin
                pipe_vld_q[i] <= 1'b0;
                pipe_rsp_q[i] <= '0;
            end
        end else begin
            out_q      <= out_d;
            pipe_vld_q <= pipe_vld_d;
            pipe_rsp_q <= pipe_rsp_d;
        end
    end

    // Program image survives reset.
    always_ff @(posedge clk) begin
        if (prog_we) begin
            ram_q[prog_addr] <= prog_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (fifo_push) begin
            assert (!fifo_full);
        end
    end

    imem_rsp_fifo #(
        .DEPTH(QDEPTH)
    ) u_rsp_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (fifo_push),
        .push_data(pipe_rsp_q[LAT-1]),
        .pop      (pop),
        .head     (head),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

endmodule

// File: tb/tb_imem_responder.sv
// tb/tb_imem_responder.sv - self-checking bench for imem_responder
module tb_imem_responder;

    localparam int LAT = 2;

    typedef struct {
        int          avail;
        logic [31:0] instr;
        logic        err;
    } exp_t;

    typedef struct {
        logic [31:0] instr;
        logic        err;
        int          cyc;
    } got_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [31:0] req_addr = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_instr;
    logic        rsp_err;
    logic        prog_we = 1'b0;
    logic [7:0]  prog_addr = '0;
    logic [31:0] prog_wdata = '0;

    int          errors = 0;
    int          checks = 0;
    int          cyc = 0;
    logic [31:0] mdl_mem [256];
    exp_t        q[$];
    got_t        got[$];
    int          accs[$];
    logic [31:0] words [4];

    imem_responder #(.DEPTH(256), .LAT(LAT), .QDEPTH(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_addr  (req_addr),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_instr (rsp_instr),
        .rsp_err   (rsp_err),
        .prog_we   (prog_we),
        .prog_addr (prog_addr),
        .prog_wdata(prog_wdata)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic exp_t model_rsp(input logic [31:0] a, input int avail);
        exp_t e;
        e.avail = avail;
        e.err   = (a[1:0] != 2'b00) || (a >= 32'd1024);
        e.instr = e.err ? 32'h0 : mdl_mem[a[9:2]];
        return e;
    endfunction

    // Scoreboard: a response is due LAT edges after its accept edge, in accept order.
    always @(negedge clk) begin
        if (!rst) begin
            check("rst_rsp_valid", {31'b0, rsp_valid}, 0);
            check("rst_req_ready", {31'b0, req_ready}, 0);
            check("rst_rsp_instr", rsp_instr, 0);
            check("rst_rsp_err", {31'b0, rsp_err}, 0);
            q.delete();
        end else begin
            automatic logic exp_v = (q.size() > 0) && (q[0].avail <= cyc);
            check("rsp_valid", {31'b0, rsp_valid}, {31'b0, exp_v});
            check("req_ready", {31'b0, req_ready}, {31'b0, q.size() < 4});
            if (exp_v) begin
                check("rsp_instr", rsp_instr, q[0].instr);
                check("rsp_err", {31'b0, rsp_err}, {31'b0, q[0].err});
                if (rsp_ready) begin
                    got.push_back('{instr: rsp_instr, err: rsp_err, cyc: cyc});
                    void'(q.pop_front());
                end
            end
            if (req_valid && req_ready) begin
                q.push_back(model_rsp(req_addr, cyc + 1 + LAT));
                accs.push_back(cyc + 1);
                check("outstanding_max", {31'b0, q.size() <= 4}, 1);
            end
            if (prog_we) mdl_mem[prog_addr] = prog_wdata;
        end
    end

    task automatic prog_write(input logic [7:0] a, input logic [31:0] d);
        prog_we = 1'b1; prog_addr = a; prog_wdata = d;
        @(posedge clk); #1;
        prog_we = 1'b0;
    endtask

    task automatic send(input logic [31:0] a);
        logic acc;
        int   b = 0;
        req_valid = 1'b1;
        req_addr  = a;
        do begin
            acc = req_ready;
            @(posedge clk); #1;
            b++;
        end while (!acc && b < 100);
        req_valid = 1'b0;
        if (!acc) check("send_timeout", 0, 1);
    endtask

    task automatic wait_pops(input string name, input int n);
        for (int i = 0; i < 200 && got.size() < n; i++) @(posedge clk);
        #1;
        check(name, got.size(), n);
    endtask

    function automatic logic [31:0] rand_addr();
        int r = $urandom % 8;
        int w = $urandom % 16;
        if (r < 6) return 32'(w << 2);
        if (r == 6) return 32'(w << 2) | 32'($urandom_range(1, 3));
        if ($urandom % 2 == 1) return 32'h400 + 32'(w << 2);
        return $urandom | 32'h0000_0400;
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int   sent;
        int   cycles;
        logic acc;
        words[0] = 32'h2001_0005; words[1] = 32'h2002_0007;
        words[2] = 32'h0022_1820; words[3] = 32'hAC03_0000;

        repeat (3) @(posedge clk);
        #1;
        check("reset_req_ready", {31'b0, req_ready}, 0);
        check("reset_rsp_valid", {31'b0, rsp_valid}, 0);
        check("reset_rsp_instr", rsp_instr, 0);
        rst = 1'b1;
        #1;
        check("post_reset_req_ready", {31'b0, req_ready}, 1);

        for (int i = 0; i < 4; i++) prog_write(8'(i), words[i]);

        // Back-to-back fetches with the core always ready
        rsp_ready = 1'b1;
        got.delete(); accs.delete();
        for (int i = 0; i < 4; i++) send(32'(i * 4));
        wait_pops("t1_pops", 4);
        for (int i = 0; i < 4; i++) begin
            check("t1_instr", got[i].instr, words[i]);
            check("t1_err", {31'b0, got[i].err}, 0);
            check("t1_spacing", got[i].cyc - got[0].cyc, i);
        end
        check("t1_latency", got[0].cyc - accs[0], LAT);

        // Misaligned and out-of-range requests, then a good one
        got.delete();
        send(32'h6); send(32'h400); send(32'h0);
        wait_pops("t2_pops", 3);
        check("t2_err0", {31'b0, got[0].err}, 1);
        check("t2_instr0", got[0].instr, 32'h0);
        check("t2_err1", {31'b0, got[1].err}, 1);
        check("t2_instr1", got[1].instr, 32'h0);
        check("t2_err2", {31'b0, got[2].err}, 0);
        check("t2_instr2", got[2].instr, 32'h2001_0005);

        // Backpressure: four credits, then stall
        rsp_ready = 1'b0;
        got.delete();
        for (int i = 0; i < 4; i++) send(32'(i * 4));
        check("t3_full_ready", {31'b0, req_ready}, 0);
        repeat (10) begin
            @(negedge clk);
            check("t3_hold_instr", rsp_instr, 32'h2001_0005);
        end
        @(posedge clk); #1;
        rsp_ready = 1'b1;
        #1;
        check("t3_ready_before_pop", {31'b0, req_ready}, 0);
        @(posedge clk); #1;
        check("t3_ready_after_pop", {31'b0, req_ready}, 1);
        wait_pops("t3_pops", 4);
        for (int i = 0; i < 4; i++) check("t3_order", got[i].instr, words[i]);

        // Same-cycle program write and read of word 1
        got.delete();
        prog_we = 1'b1; prog_addr = 8'd1; prog_wdata = 32'hDEAD_BEEF;
        send(32'h4);
        prog_we = 1'b0;
        send(32'h4);
        wait_pops("t4_pops", 2);
        check("t4_old_word", got[0].instr, 32'h2002_0007);
        check("t4_new_word", got[1].instr, 32'hDEAD_BEEF);

        // Reset with three requests in flight
        got.delete();
        send(32'h0); send(32'h4); send(32'h8);
        rst = 1'b0;
        #1;
        check("t5_valid_in_reset", {31'b0, rsp_valid}, 0);
        check("t5_instr_in_reset", rsp_instr, 0);
        @(posedge clk); #1;
        rst = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        check("t5_no_stale", got.size(), 0);
        send(32'h8);
        wait_pops("t5_pops", 1);
        check("t5_instr", got[0].instr, 32'h0022_1820);

        // Randomised traffic against the scoreboard
        for (int i = 0; i < 16; i++) prog_write(8'(i), 32'h1000_0000 + 32'(i * 32'h111));
        got.delete(); accs.delete();
        sent = 0; cycles = 0;
        while (sent < 1000 && cycles < 20000) begin
            req_valid  = ($urandom % 4) != 0;
            req_addr   = rand_addr();
            rsp_ready  = ($urandom % 2) == 1;
            prog_we    = ($urandom % 8) == 0;
            prog_addr  = 8'($urandom % 16);
            prog_wdata = $urandom;
            acc = req_valid && req_ready;
            @(posedge clk); #1;
            cycles++;
            if (acc) sent++;
        end
        req_valid = 1'b0; prog_we = 1'b0; rsp_ready = 1'b1;
        check("t6_sent", sent, 1000);
        for (int i = 0; i < 200 && q.size() > 0; i++) @(posedge clk);
        #1;
        check("t6_drained", q.size(), 0);
        check("t6_pops", got.size(), 1000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/imem_responder.md
Name: imem_responder

Overview:
- Instruction-memory responder: the memory end of the fetch interface that the core datapath initiates.
- Accepts fetch requests (byte address), reads a word-organised program RAM and returns the instruction word in order, with fixed latency and backpressure.
- Includes a program-load write port so a test harness or boot loader can fill the RAM before or while the core runs.
- Sits between the core's pc/instr pair and the program image.

Parameters:
- DEPTH, 256, number of 32-bit instruction words (power of two)
- LAT, 2, cycles from request acceptance to earliest rsp_valid (LAT >= 1)
- QDEPTH, 4, maximum outstanding requests (accepted, response not yet consumed)

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-low
- req_valid  in  1  fetch request present
- req_ready  out  1  responder can accept a request this cycle
- req_addr  in  32  byte address (pc)
- rsp_valid  out  1  response word available
- rsp_ready  in  1  core consumes response this cycle
- rsp_instr  out  32  instruction word (NOP 32'h0000_0000 on error)
- rsp_err  out  1  request was misaligned or out of range
- prog_we  in  1  program RAM write enable
- prog_addr  in  $clog2(DEPTH)  word index for program write
- prog_wdata  in  32  program word

Behaviour:
- Reset (rst low, asynchronous): req_ready=0 while asserted, rsp_valid=0, rsp_instr=0, rsp_err=0. Outstanding count, latency pipeline and response FIFO are cleared. RAM contents are NOT cleared. First cycle after release: req_ready=1.
- Accept: a transfer occurs on a rising edge with req_valid && req_ready. req_ready = (outstanding < QDEPTH). outstanding counts accepted requests not yet popped by rsp_valid && rsp_ready.
- Addressing: word index = req_addr[$clog2(DEPTH)+1:2].
  - Error if req_addr[1:0] != 0 or req_addr >= 4*DEPTH.
  - On error: response carries rsp_err=1 and rsp_instr=NOP. Errors do not stall and do not block later requests.
- Read timing: RAM read in the acceptance cycle; data and error flag shift through an LAT-stage valid pipeline and then enter a response FIFO of depth QDEPTH. The credit check guarantees the FIFO never overflows.
- Output:
  - rsp_valid = FIFO non-empty.
  - Earliest rsp_valid is LAT cycles after the accept edge. With rsp_ready held high, back-to-back requests yield one response per cycle.
  - rsp_instr and rsp_err are held stable while rsp_valid && !rsp_ready.
- Ordering: responses are strictly in request order.
- Simultaneous pop and accept in one cycle: outstanding is unchanged. This is allowed even when outstanding == QDEPTH is reached combinationally only after the pop? No: req_ready uses the registered count, so at full there is no accept until the cycle after the pop.
- Program write: prog_we writes prog_wdata into RAM at prog_addr on the edge. If the same word is written and read in the same cycle, the request returns the OLD word (read-before-write). The write is visible to requests accepted on following edges.
- Reset mid-operation: all in-flight requests are dropped and no responses emerge afterwards. The core must reissue its fetch.
- Width rules:
  - outstanding is $clog2(QDEPTH+1) bits. It never wraps, by construction.
  - FIFO pointers are $clog2(QDEPTH) bits plus a wrap bit, and wrap modulo QDEPTH.

Decomposition:
- Shared package (imem_pkg):
  - NOP_INSTR = 32'h0000_0000
  - word-address slice helper
  - typedef rsp_t {logic [31:0] instr; logic err;}
- One sub-module: imem_rsp_fifo, a parameterised synchronous FIFO of rsp_t with push/pop/full/empty and the same async active-low reset.
- The RAM, latency pipeline and credit counter stay in imem_responder.

Test Plan:
- Load words 0..3 = 32'h2001_0005, 32'h2002_0007, 32'h0022_1820, 32'hAC03_0000. With rsp_ready=1, request 0x0,0x4,0x8,0xC back-to-back -> responses in that order, first at accept+2 cycles, one per cycle, rsp_err=0.
- Request 0x6 (misaligned), then 0x400 (DEPTH=256, out of range) -> two responses with rsp_err=1 and rsp_instr=0; the following request 0x0 returns 32'h2001_0005.
- Hold rsp_ready=0 and issue requests -> req_ready drops after the 4th accept. rsp_instr stays 32'h2001_0005 for 10 cycles. Raising rsp_ready drains 4 responses in order, and req_ready returns the cycle after the first pop.
- Same cycle prog_we=1, prog_addr=1, prog_wdata=32'hDEAD_BEEF and request 0x4 -> that response returns 32'h2002_0007. The next request to 0x4 returns 32'hDEAD_BEEF.
- Accept 3 requests, assert rst low mid-flight for 1 cycle -> rsp_valid=0 immediately and no stale response appears. After release, request 0x8 returns 32'h0022_1820 with RAM contents intact.
- Random valid/ready toggling over 1000 requests, compared against a scoreboard -> no lost, duplicated or reordered responses, and outstanding never exceeds 4.
